// File: rtl/pfd_tdc.sv
// -----------------------------------------------------------------------------
// pfd_tdc -- phase/frequency detector with time-to-digital phase-error output
//
// Purpose:
//    Samples a reference clock (link) and a feedback clock (vco) in the clk
//    domain, finds their rising edges, and measures how many clk cycles one
//    leads the other. A tri-state FSM (IDLE/LEAD/LAG) drives charge-pump
//    up/dn requests and emits a signed error word at the end of each
//    measurement. A repeated edge from the same side before the other side
//    arrives is reported as a full-scale error (frequency detection).
//
// Parameters:
//    ERR_W     width of the signed error word (4..16)
//    LOCK_TOL  largest |err| counted as in-lock
//    LOCK_CYC  consecutive in-lock measurements needed for locked
//
// Ports:
//    clk        in   sampling clock, all state on its rising edge
//    rst_n      in   asynchronous active-low reset
//    link       in   reference clock (asynchronous to clk)
//    vco        in   feedback clock (asynchronous to clk)
//    up         out  reference leads (LEAD state)
//    dn         out  feedback leads (LAG state)
//    setting    out  charge-pump code {dn, up|dn}
//    err        out  signed phase error in clk cycles, held between strobes
//    err_valid  out  one-cycle strobe for a new err value
//    locked     out  lock indicator
//
// Configuration:
//    PFD_TDC_LOCK_DETECT_EN  when defined, builds the lock counter; otherwise
//                            locked is tied low.
// -----------------------------------------------------------------------------
module pfd_tdc #(
   parameter int ERR_W    = 8,
   parameter int LOCK_TOL = 2,
   parameter int LOCK_CYC = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             link,
   input  logic             vco,
   output logic             up,
   output logic             dn,
   output logic [1:0]       setting,
   output logic [ERR_W-1:0] err,
   output logic             err_valid,
   output logic             locked
);

   // Counter is one bit narrower than err, so its all-ones value is exactly
   // the largest positive error and -2^(ERR_W-1) can never be produced.
   localparam int CW = ERR_W - 1;
   localparam logic [CW-1:0]    CNT_MAX = '1;
   localparam logic [CW-1:0]    CNT_ONE = CW'(1);
   localparam logic [ERR_W-1:0] ERR_POS_MAX = {1'b0, CNT_MAX};
   localparam logic [ERR_W-1:0] ERR_NEG_MAX = ERR_W'(0) - {1'b0, CNT_MAX};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LEAD = 2'd1,
      LAG  = 2'd2
   } state_t;

   // -------------------------------------------------------------------------
   // Edge detection: two synchroniser flops plus a history flop per input.
   // Index 0 = link, index 1 = vco.
   // -------------------------------------------------------------------------
   logic [1:0] async_in;
   logic [1:0] edge_e;
   logic       link_e;
   logic       vco_e;

   assign async_in = {vco, link};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         logic s1_reg;
         logic s2_reg;
         logic hist_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_reg   <= 1'b0;
               s2_reg   <= 1'b0;
               hist_reg <= 1'b0;
            end else begin
               s1_reg   <= async_in[gi];
               s2_reg   <= s1_reg;
               hist_reg <= s2_reg;
            end
         end

         assign edge_e[gi] = s2_reg & ~hist_reg;
      end
   endgenerate

   assign link_e = edge_e[0];
   assign vco_e  = edge_e[1];

   // -------------------------------------------------------------------------
   // Measurement FSM
   // -------------------------------------------------------------------------
   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [ERR_W-1:0] err_reg, err_next;
   logic             err_valid_reg, err_valid_next;
   logic             up_reg, dn_reg;
   logic [CW-1:0]    cnt_inc;

   assign cnt_inc = (cnt_reg == CNT_MAX) ? CNT_MAX : (cnt_reg + CNT_ONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         err_reg       <= '0;
         err_valid_reg <= 1'b0;
         up_reg        <= 1'b0;
         dn_reg        <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         err_reg       <= err_next;
         err_valid_reg <= err_valid_next;
         // up/dn follow the state being entered, so they are mutually
         // exclusive and rise the cycle after the opening strobe.
         up_reg        <= (state_next == LEAD);
         dn_reg        <= (state_next == LAG);
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      err_next       = err_reg;
      err_valid_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (link_e && vco_e) begin
               err_next       = '0;
               err_valid_next = 1'b1;
            end else if (link_e) begin
               state_next = LEAD;
               cnt_next   = CNT_ONE;
            end else if (vco_e) begin
               state_next = LAG;
               cnt_next   = CNT_ONE;
            end
         end

         LEAD: begin
            if (vco_e) begin
               // Closing edge wins over a coincident link edge; the pair
               // does not open a new measurement.
               err_next       = {1'b0, cnt_reg};
               err_valid_next = 1'b1;
               state_next     = IDLE;
               cnt_next       = '0;
            end else if (link_e) begin
               // Second reference edge with no feedback edge: frequency error.
               err_next       = ERR_POS_MAX;
               err_valid_next = 1'b1;
               cnt_next       = CNT_ONE;
            end else begin
               cnt_next = cnt_inc;
            end
         end

         LAG: begin
            if (link_e) begin
               err_next       = ERR_W'(0) - {1'b0, cnt_reg};
               err_valid_next = 1'b1;
               state_next     = IDLE;
               cnt_next       = '0;
            end else if (vco_e) begin
               err_next       = ERR_NEG_MAX;
               err_valid_next = 1'b1;
               cnt_next       = CNT_ONE;
            end else begin
               cnt_next = cnt_inc;
            end
         end

         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign up        = up_reg;
   assign dn        = dn_reg;
   assign setting   = {dn_reg, up_reg | dn_reg};
   assign err       = err_reg;
   assign err_valid = err_valid_reg;

   // -------------------------------------------------------------------------
   // Lock detection
   // -------------------------------------------------------------------------
`ifdef PFD_TDC_LOCK_DETECT_EN
   localparam int LW = $clog2(LOCK_CYC + 1);

   logic [LW-1:0]    lock_cnt_reg;
   logic [ERR_W-1:0] err_abs;

   // err is never the most negative value, so the negation cannot overflow.
   assign err_abs = err_reg[ERR_W-1] ? (ERR_W'(0) - err_reg) : err_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt_reg <= '0;
      end else if (err_valid_reg) begin
         if (err_abs <= ERR_W'(LOCK_TOL)) begin
            if (lock_cnt_reg != LW'(LOCK_CYC)) begin
               lock_cnt_reg <= lock_cnt_reg + LW'(1);
            end
         end else begin
            lock_cnt_reg <= '0;
         end
      end
   end

   assign locked = (lock_cnt_reg == LW'(LOCK_CYC));
`else
   localparam int unused_lock_cfg = LOCK_TOL + LOCK_CYC;

   assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_tdc.sv
// -----------------------------------------------------------------------------
// tb_pfd_tdc -- directed self-checking bench for pfd_tdc (ERR_W = 8)
//
// Inputs change 1 time unit after a rising clk edge; outputs are sampled at
// the same point, away from the active edge. An input change made there is
// acted on by the FSM at the 3rd following rising edge.
// -----------------------------------------------------------------------------
module tb_pfd_tdc;

   localparam int ERR_W = 8;

   logic             clk;
   logic             rst_n;
   logic             link;
   logic             vco;
   logic             up;
   logic             dn;
   logic [1:0]       setting;
   logic [ERR_W-1:0] err;
   logic             err_valid;
   logic             locked;

   int n_cmp;
   int n_bad;

   pfd_tdc #(
      .ERR_W    (ERR_W),
      .LOCK_TOL (2),
      .LOCK_CYC (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .link      (link),
      .vco       (vco),
      .up        (up),
      .dn        (dn),
      .setting   (setting),
      .err       (err),
      .err_valid (err_valid),
      .locked    (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [31:0] serr();
      return 32'(int'($signed(err)));
   endfunction

   int lock_exp;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      link  = 1'b0;
      vco   = 1'b0;

      // Reset state
      #2;
      chk("rst_up", 32'(up), 0);
      chk("rst_dn", 32'(dn), 0);
      chk("rst_setting", 32'(setting), 0);
      chk("rst_err", serr(), 0);
      chk("rst_err_valid", 32'(err_valid), 0);
      chk("rst_locked", 32'(locked), 0);
      tick();
      rst_n = 1'b1;
      ticks(2);

      // Coincident edges -> err = 0, no up/dn
      link = 1'b1;
      vco  = 1'b1;
      ticks(2);
      chk("coinc_pre_valid", 32'(err_valid), 0);
      tick();
      chk("coinc_valid", 32'(err_valid), 1);
      chk("coinc_err", serr(), 0);
      chk("coinc_up", 32'(up), 0);
      chk("coinc_dn", 32'(dn), 0);
      tick();
      chk("coinc_strobe_1cyc", 32'(err_valid), 0);
      link = 1'b0;
      vco  = 1'b0;
      ticks(4);

      // link leads vco by 5 -> err = +5
      link = 1'b1;
      ticks(3);
      chk("lead5_up", 32'(up), 1);
      chk("lead5_dn", 32'(dn), 0);
      chk("lead5_setting", 32'(setting), 1);
      ticks(2);
      vco = 1'b1;
      ticks(2);
      chk("lead5_up_held", 32'(up), 1);
      chk("lead5_pre_valid", 32'(err_valid), 0);
      tick();
      chk("lead5_valid", 32'(err_valid), 1);
      chk("lead5_err", serr(), 5);
      chk("lead5_up_off", 32'(up), 0);
      chk("lead5_setting_off", 32'(setting), 0);
      tick();
      chk("lead5_valid_off", 32'(err_valid), 0);
      chk("lead5_err_hold", serr(), 5);
      link = 1'b0;
      vco  = 1'b0;
      ticks(4);

      // vco leads link by 300 -> saturated err = -127
      vco = 1'b1;
      ticks(3);
      chk("lag300_dn", 32'(dn), 1);
      chk("lag300_up", 32'(up), 0);
      chk("lag300_setting", 32'(setting), 3);
      ticks(2);
      vco = 1'b0;
      ticks(295);
      link = 1'b1;
      ticks(2);
      chk("lag300_dn_held", 32'(dn), 1);
      chk("lag300_pre_valid", 32'(err_valid), 0);
      tick();
      chk("lag300_valid", 32'(err_valid), 1);
      chk("lag300_err", serr(), -127);
      chk("lag300_dn_off", 32'(dn), 0);
      link = 1'b0;
      ticks(4);

      // Two link edges 40 apart -> +127, stay LEAD, then vco 7 later -> +7
      link = 1'b1;
      ticks(3);
      chk("freq_up", 32'(up), 1);
      ticks(2);
      link = 1'b0;
      ticks(35);
      link = 1'b1;
      ticks(2);
      chk("freq_pre_valid", 32'(err_valid), 0);
      tick();
      chk("freq_valid", 32'(err_valid), 1);
      chk("freq_err", serr(), 127);
      chk("freq_up_stays", 32'(up), 1);
      ticks(2);
      link = 1'b0;
      ticks(2);
      vco = 1'b1;
      ticks(2);
      chk("freq7_up", 32'(up), 1);
      tick();
      chk("freq7_valid", 32'(err_valid), 1);
      chk("freq7_err", serr(), 7);
      chk("freq7_up_off", 32'(up), 0);
      vco = 1'b0;
      ticks(4);

      // Lock detection: 16 measurements of +1, then +3
      for (int m = 1; m <= 16; m++) begin
         link = 1'b1;
         tick();
         vco = 1'b1;
         ticks(3);
         chk($sformatf("lock_err_%0d", m), serr(), 1);
         link = 1'b0;
         vco  = 1'b0;
         tick();
`ifdef PFD_TDC_LOCK_DETECT_EN
         lock_exp = (m == 16) ? 1 : 0;
`else
         lock_exp = 0;
`endif
         chk($sformatf("lock_state_%0d", m), 32'(locked), 32'(lock_exp));
         ticks(3);
      end
      link = 1'b1;
      ticks(3);
      vco = 1'b1;
      ticks(3);
      chk("unlock_valid", 32'(err_valid), 1);
      chk("unlock_err", serr(), 3);
`ifdef PFD_TDC_LOCK_DETECT_EN
      lock_exp = 1;
`else
      lock_exp = 0;
`endif
      chk("unlock_still_locked", 32'(locked), 32'(lock_exp));
      tick();
      chk("unlock_locked_drop", 32'(locked), 0);
      link = 1'b0;
      vco  = 1'b0;
      ticks(4);

      // Reset in the middle of LEAD, then a clean +4 measurement
      link = 1'b1;
      ticks(3);
      chk("mid_up", 32'(up), 1);
      ticks(10);
      rst_n = 1'b0;
      link  = 1'b0;
      #1;
      chk("mid_rst_up", 32'(up), 0);
      chk("mid_rst_err", serr(), 0);
      chk("mid_rst_valid", 32'(err_valid), 0);
      chk("mid_rst_setting", 32'(setting), 0);
      ticks(2);
      chk("mid_rst_valid_hold", 32'(err_valid), 0);
      rst_n = 1'b1;
      ticks(3);
      chk("post_rst_valid", 32'(err_valid), 0);
      link = 1'b1;
      ticks(3);
      chk("post_rst_up", 32'(up), 1);
      tick();
      vco = 1'b1;
      ticks(2);
      chk("post_rst_pre_valid", 32'(err_valid), 0);
      tick();
      chk("post_rst_valid4", 32'(err_valid), 1);
      chk("post_rst_err4", serr(), 4);
      link = 1'b0;
      vco  = 1'b0;
      ticks(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
